can_bit_destuffer: RTL and testbench

- Sits directly upstream of the frame decoder.
- Takes raw sampled bus bits, removes stuff bits inside the stuffing region, detects stuff errors, and tracks bus-idle integration.
- Clocked by the sample-point strobe SP, one bit per edge.
- Feeds the decoder a delayed bit (RX_D) with a qualifier (BIT_VALID), and drives the decoder's active-low ERROR input.
- Classic CAN stuffing only; CAN FD fixed-stuff CRC handling is out of scope.

---
 rtl/can_bit_destuffer_if.sv | 12 +
 rtl/can_bit_destuffer.sv | 98 +++++++++
 tb/tb_can_bit_destuffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/can_bit_destuffer_if.sv
// can_bit_destuffer_if: raw-bit input and decoder-facing outputs of the CAN bit destuffer.
interface can_bit_destuffer_if;
   logic       RX_RAW;
   logic       F_CRC_Dw;
   logic       RX_D;
   logic       BIT_VALID;
   logic       ERROR;
   logic       BUS_IDLE;
   logic [7:0] STF_ERR_CNT;
   modport master (output RX_RAW, F_CRC_Dw, input RX_D, BIT_VALID, ERROR, BUS_IDLE, STF_ERR_CNT);
   modport slave  (input RX_RAW, F_CRC_Dw, output RX_D, BIT_VALID, ERROR, BUS_IDLE, STF_ERR_CNT);
endinterface

// File: rtl/can_bit_destuffer.sv
// can_bit_destuffer: removes CAN stuff bits, flags stuff errors and tracks bus-idle integration.
module can_bit_destuffer #(
   parameter int STUFF_LEN    = 5,
   parameter int IDLE_BITS    = 11,
   parameter int EOF_INT_BITS = 10
) (
   input logic                 SP,
   input logic                 reset,
   can_bit_destuffer_if.slave  bus
);
   typedef enum logic [1:0] {WAIT_IDLE, BUS_IDLE, STUFF, NOSTUFF} state_t;
   localparam logic [2:0] SLEN = 3'(STUFF_LEN);
   localparam logic [3:0] IDLE_N = 4'(IDLE_BITS);
   localparam logic [3:0] EOF_N = 4'(EOF_INT_BITS);
   state_t     state_q, state_d;
   logic       last_bit_q, last_bit_d;
   logic [2:0] same_cnt_q, same_cnt_d;
   logic [3:0] rec_cnt_q, rec_cnt_d, rec_inc;
   logic       rx_d_q, valid_q, valid_d, error_q, error_d, idle_q;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       stuff_bit, stuff_err;
   assign rec_inc   = rec_cnt_q + 4'd1;
   assign stuff_bit = same_cnt_q == SLEN;
   assign stuff_err = stuff_bit && (bus.RX_RAW == last_bit_q);
   always_comb begin
      state_d    = state_q;
      last_bit_d = last_bit_q;
      same_cnt_d = same_cnt_q;
      rec_cnt_d  = rec_cnt_q;
      valid_d    = 1'b0;
      error_d    = 1'b1;
      err_cnt_d  = err_cnt_q;
      case (state_q)
         WAIT_IDLE: begin
            rec_cnt_d = bus.RX_RAW ? rec_inc : 4'd0;
            if (bus.RX_RAW && rec_inc == IDLE_N) begin
               state_d   = BUS_IDLE;
               rec_cnt_d = 4'd0;
            end
         end
         BUS_IDLE: begin
            valid_d = 1'b1;
            if (!bus.RX_RAW) begin
               state_d    = STUFF;
               same_cnt_d = 3'd1;
               last_bit_d = 1'b0;
            end
         end
         STUFF: begin
            // A stuff bit (good or bad) always restarts the run at 1.
            valid_d    = !stuff_bit;
            same_cnt_d = (stuff_bit || bus.RX_RAW != last_bit_q) ? 3'd1 : same_cnt_q + 3'd1;
            last_bit_d = bus.RX_RAW;
            rec_cnt_d  = 4'd0;
            error_d    = !stuff_err;
            err_cnt_d  = (stuff_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
            state_d    = stuff_err ? WAIT_IDLE : (!bus.F_CRC_Dw ? NOSTUFF : STUFF);
         end
         NOSTUFF: begin
            valid_d   = 1'b1;
            rec_cnt_d = bus.RX_RAW ? rec_inc : 4'd0;
            if (bus.RX_RAW && rec_inc == EOF_N) begin
               state_d   = BUS_IDLE;
               rec_cnt_d = 4'd0;
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end
   always_ff @(posedge SP) begin
      if (reset) begin
         state_q    <= WAIT_IDLE;
         last_bit_q <= 1'b1;
         same_cnt_q <= 3'd0;
         rec_cnt_q  <= 4'd0;
         rx_d_q     <= 1'b1;
         valid_q    <= 1'b0;
         error_q    <= 1'b1;
         idle_q     <= 1'b0;
         err_cnt_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         last_bit_q <= last_bit_d;
         same_cnt_q <= same_cnt_d;
         rec_cnt_q  <= rec_cnt_d;
         rx_d_q     <= bus.RX_RAW;
         valid_q    <= valid_d;
         error_q    <= error_d;
         idle_q     <= state_d == BUS_IDLE;
         err_cnt_q  <= err_cnt_d;
      end
   end
   assign bus.RX_D        = rx_d_q;
   assign bus.BIT_VALID   = valid_q;
   assign bus.ERROR       = error_q;
   assign bus.BUS_IDLE    = idle_q;
   assign bus.STF_ERR_CNT = err_cnt_q;
endmodule

// File: tb/tb_can_bit_destuffer.sv
// tb_can_bit_destuffer: directed vector table plus hand sequences for reset and counter saturation.
module tb_can_bit_destuffer;
   typedef struct {
      logic       r, rx, fc;
      logic       rxd, bv, er, idl;
      logic [7:0] cnt;
   } vec_t;
   logic SP = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t q[$];
   can_bit_destuffer_if bus();
   can_bit_destuffer dut (.SP(SP), .reset(reset), .bus(bus));
   always #5 SP = ~SP;
   function automatic void addn(input int n, input logic r, rx, fc, rxd, bv, er, idl, input logic [7:0] cnt);
      for (int i = 0; i < n; i++) q.push_back('{r, rx, fc, rxd, bv, er, idl, cnt});
   endfunction
   task automatic chk(input string nm, input int idx, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, a, e);
      end
   endtask
   task automatic step(input logic r, input logic rx, input logic fc);
      @(negedge SP);
      reset = r;
      bus.RX_RAW = rx;
      bus.F_CRC_Dw = fc;
      @(posedge SP);
      #1;
   endtask
   task automatic chk_all(input string nm, input int idx, input logic rxd, bv, er, idl, input logic [7:0] cnt);
      chk({nm, ".rx_d"}, idx, {7'd0, bus.RX_D}, {7'd0, rxd});
      chk({nm, ".valid"}, idx, {7'd0, bus.BIT_VALID}, {7'd0, bv});
      chk({nm, ".error"}, idx, {7'd0, bus.ERROR}, {7'd0, er});
      chk({nm, ".idle"}, idx, {7'd0, bus.BUS_IDLE}, {7'd0, idl});
      chk({nm, ".cnt"}, idx, bus.STF_ERR_CNT, cnt);
   endtask
   initial begin
      bus.RX_RAW = 1'b1;
      bus.F_CRC_Dw = 1'b1;
      // reset then idle integration
      addn(2, 1, 1, 1, 1, 0, 1, 0, 0);
      addn(10, 0, 1, 1, 1, 0, 1, 0, 0);
      addn(1, 0, 1, 1, 1, 0, 1, 1, 0);
      addn(1, 0, 1, 1, 1, 1, 1, 1, 0);
      // SOF + four dominant, recessive stuff bit, then data
      addn(5, 0, 0, 1, 0, 1, 1, 0, 0);
      addn(1, 0, 1, 1, 1, 0, 1, 0, 0);
      addn(1, 0, 0, 1, 0, 1, 1, 0, 0);
      // CRC delimiter entry, then 1,0,1,0 and ten recessive
      addn(1, 0, 1, 0, 1, 1, 1, 0, 0);
      addn(1, 0, 1, 1, 1, 1, 1, 0, 0);
      addn(1, 0, 0, 1, 0, 1, 1, 0, 0);
      addn(1, 0, 1, 1, 1, 1, 1, 0, 0);
      addn(1, 0, 0, 1, 0, 1, 1, 0, 0);
      addn(9, 0, 1, 1, 1, 1, 1, 0, 0);
      addn(1, 0, 1, 1, 1, 1, 1, 1, 0);
      // dominant at the 4th recessive position restarts EOF count
      addn(1, 0, 0, 1, 0, 1, 1, 0, 0);
      addn(1, 0, 1, 0, 1, 1, 1, 0, 0);
      addn(3, 0, 1, 1, 1, 1, 1, 0, 0);
      addn(1, 0, 0, 1, 0, 1, 1, 0, 0);
      addn(9, 0, 1, 1, 1, 1, 1, 0, 0);
      addn(1, 0, 1, 1, 1, 1, 1, 1, 0);
      // six dominant: stuff error, then 11-bit reintegration
      addn(5, 0, 0, 1, 0, 1, 1, 0, 0);
      addn(1, 0, 0, 1, 0, 0, 0, 0, 1);
      addn(10, 0, 1, 1, 1, 0, 1, 0, 1);
      addn(1, 0, 1, 1, 1, 0, 1, 1, 1);
      // stuff error on the F_CRC_Dw edge: error wins
      addn(5, 0, 0, 1, 0, 1, 1, 0, 1);
      addn(1, 0, 0, 0, 0, 0, 0, 0, 2);
      addn(10, 0, 1, 1, 1, 0, 1, 0, 2);
      addn(1, 0, 1, 1, 1, 0, 1, 1, 2);
      // good dominant stuff bit on the F_CRC_Dw edge
      addn(1, 0, 0, 1, 0, 1, 1, 0, 2);
      addn(5, 0, 1, 1, 1, 1, 1, 0, 2);
      addn(1, 0, 0, 0, 0, 0, 1, 0, 2);
      addn(9, 0, 1, 1, 1, 1, 1, 0, 2);
      addn(1, 0, 1, 1, 1, 1, 1, 1, 2);
      foreach (q[i]) begin
         step(q[i].r, q[i].rx, q[i].fc);
         chk_all("vec", i, q[i].rxd, q[i].bv, q[i].er, q[i].idl, q[i].cnt);
      end
      // reset mid-frame with same_cnt=4
      for (int i = 0; i < 4; i++) step(0, 0, 1);
      chk_all("pre_rst", 0, 0, 1, 1, 0, 2);
      step(1, 0, 1);
      chk_all("mid_rst", 0, 1, 0, 1, 0, 0);
      step(0, 0, 1);
      chk_all("no_sof", 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 1);
      chk_all("reint10", 0, 1, 0, 1, 0, 0);
      step(0, 1, 1);
      chk_all("reint11", 0, 1, 0, 1, 1, 0);
      // 257 stuff errors: counter saturates at 255
      for (int k = 1; k <= 257; k++) begin
         for (int i = 0; i < 6; i++) step(0, 0, 1);
         if (k == 1 || k >= 254) chk_all("sat_err", k, 0, 0, 0, 0, (k > 255) ? 8'hFF : 8'(k));
         for (int i = 0; i < 11; i++) step(0, 1, 1);
      end
      chk_all("sat_end", 0, 1, 0, 1, 1, 8'hFF);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
